// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU definitions: MemOP funct3 codes, FSM states,
// error codes and the latched-op bundle.
package lsu_ctrl_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OP   = 2'b01;
  localparam logic [1:0] ERR_MIS  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic       we;
    logic [2:0] op;
    logic [1:0] alo;
    logic [4:0] rd;
  } lsu_op_t;

  function automatic logic op_legal(
    input logic       we,
    input logic [2:0] op
  );
    logic ok;
    ok = (op == OP_B) || (op == OP_H) || (op == OP_W);
    if (!we)
      ok = ok || (op == OP_BU) || (op == OP_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store byte enables / replicated data,
// and load byte/half extraction with sign/zero extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  alo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_alo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic is_sx;
  logic [7:0]  byt;
  logic [15:0] half;

  // store side: enables and data replicated across lanes
  always_comb begin
    be   = 4'b0000;
    lane = '0;
    unique case (1'b1)
      (size == 2'b00): begin
        be   = 4'b0001 << alo;
        lane = {4{wdata[7:0]}};
      end
      (size == 2'b01): begin
        be   = 4'b0011 << {alo[1], 1'b0};
        lane = {2{wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        lane = wdata;
      end
    endcase
  end

  // load side: pick addressed lane, then extend
  always_comb begin
    is_sx   = !ld_op[2];
    byt     = rdata[{ld_alo, 3'b000} +: 8];
    half    = rdata[{ld_alo[1], 4'b0000} +: 16];
    ld_data = rdata;
    unique case (1'b1)
      (ld_op[1:0] == 2'b00):
        ld_data = {{24{is_sx & byt[7]}}, byt};
      (ld_op[1:0] == 2'b01):
        ld_data = {{16{is_sx & half[15]}}, half};
      default:
        ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one outstanding req/gnt/rvalid access.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned half/word ops.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic        Clk_i,
  input  logic        Rst_n_i,
  input  logic        Req_valid_i,
  output logic        Req_ready_o,
  input  logic        MemWrite_en_i,
  input  logic [2:0]  MemOP_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] Wdata_i,
  input  logic [4:0]  Rd_i,
  output logic        Stall_o,
  output logic        Dmem_req_o,
  input  logic        Dmem_gnt_i,
  output logic        Dmem_we_o,
  output logic [3:0]  Dmem_be_o,
  output logic [31:0] Dmem_addr_o,
  output logic [31:0] Dmem_wdata_o,
  input  logic        Dmem_rvalid_i,
  input  logic [31:0] Dmem_rdata_i,
  output logic        Ld_valid_o,
  output logic [4:0]  Ld_rd_o,
  output logic [31:0] Ld_data_o,
  output logic        Err_o,
  output logic [1:0]  Err_code_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  lsu_state_e state, state_nxt;
  lsu_op_t    cur;
  logic [CNT_W-1:0] cnt;

  logic accept, op_ok, misal, go, err_acc;
  logic busy, adv, tmo;
  logic [3:0]  be;
  logic [31:0] lane, ld_data;

  assign accept  = Req_valid_i && Req_ready_o;
  assign op_ok   = op_legal(MemWrite_en_i, MemOP_i);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misal   = ((MemOP_i[1:0] == 2'b01) && Addr_i[0])
                || ((MemOP_i[1:0] == 2'b10) && (Addr_i[1:0] != 2'b00));
`else
  assign misal   = 1'b0;
`endif
  assign go      = accept && op_ok && !misal;
  assign err_acc = accept && (!op_ok || misal);
  assign busy    = (state != S_IDLE);
  assign adv     = ((state == S_REQ) && Dmem_gnt_i)
                || ((state == S_WAIT) && Dmem_rvalid_i);
  assign tmo     = busy && !adv && (cnt >= CNT_LAST);

  lsu_align u_align (
    .size    (MemOP_i[1:0]),
    .alo     (Addr_i[1:0]),
    .wdata   (Wdata_i),
    .be      (be),
    .lane    (lane),
    .ld_op   (cur.op),
    .ld_alo  (cur.alo),
    .rdata   (Dmem_rdata_i),
    .ld_data (ld_data)
  );

  // state register
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next-state: store ends on gnt, load on rvalid
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (go) state_nxt = S_REQ;
      S_REQ: begin
        if (tmo)
          state_nxt = S_IDLE;
        else if (Dmem_gnt_i)
          state_nxt = cur.we ? S_IDLE : S_WAIT;
      end
      S_WAIT: if (tmo || Dmem_rvalid_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM-derived handshake outputs
  always_comb begin
    Req_ready_o = (state == S_IDLE);
    Stall_o     = (state != S_IDLE);
  end

  // latch op and run the watchdog
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      cur <= '0;
      cnt <= '0;
    end else if (go) begin
      cur <= '{we: MemWrite_en_i, op: MemOP_i,
               alo: Addr_i[1:0], rd: Rd_i};
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
    end
  end

  // bus request: held stable until gnt or timeout
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      Dmem_req_o   <= 1'b0;
      Dmem_we_o    <= 1'b0;
      Dmem_be_o    <= '0;
      Dmem_addr_o  <= '0;
      Dmem_wdata_o <= '0;
    end else if (go) begin
      Dmem_req_o   <= 1'b1;
      Dmem_we_o    <= MemWrite_en_i;
      Dmem_be_o    <= be;
      Dmem_addr_o  <= {Addr_i[31:2], 2'b00};
      Dmem_wdata_o <= lane;
    end else if ((state == S_REQ) && (Dmem_gnt_i || tmo)) begin
      Dmem_req_o   <= 1'b0;
    end
  end

  // load result and error pulses
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      Ld_valid_o <= 1'b0;
      Ld_rd_o    <= '0;
      Ld_data_o  <= '0;
      Err_o      <= 1'b0;
      Err_code_o <= ERR_NONE;
    end else begin
      Ld_valid_o <= (state == S_WAIT) && Dmem_rvalid_i;
      if ((state == S_WAIT) && Dmem_rvalid_i) begin
        Ld_rd_o   <= cur.rd;
        Ld_data_o <= ld_data;
      end
      Err_o <= err_acc || tmo;
      if (tmo)
        Err_code_o <= ERR_TMO;
      else if (err_acc)
        Err_code_o <= op_ok ? ERR_MIS : ERR_OP;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stores, loads, stalls,
// timeout, illegal op, misalign and mid-access reset.
module tb_lsu_ctrl;

  logic        Clk_i = 1'b0;
  logic        Rst_n_i = 1'b0;
  logic        Req_valid_i = 1'b0;
  logic        Req_ready_o;
  logic        MemWrite_en_i = 1'b0;
  logic [2:0]  MemOP_i = 3'b000;
  logic [31:0] Addr_i = '0;
  logic [31:0] Wdata_i = '0;
  logic [4:0]  Rd_i = '0;
  logic        Stall_o;
  logic        Dmem_req_o;
  logic        Dmem_gnt_i = 1'b0;
  logic        Dmem_we_o;
  logic [3:0]  Dmem_be_o;
  logic [31:0] Dmem_addr_o;
  logic [31:0] Dmem_wdata_o;
  logic        Dmem_rvalid_i = 1'b0;
  logic [31:0] Dmem_rdata_i = '0;
  logic        Ld_valid_o;
  logic [4:0]  Ld_rd_o;
  logic [31:0] Ld_data_o;
  logic        Err_o;
  logic [1:0]  Err_code_o;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_ctrl #(.MAX_WAIT(64)) dut (
    .Clk_i(Clk_i), .Rst_n_i(Rst_n_i),
    .Req_valid_i(Req_valid_i), .Req_ready_o(Req_ready_o),
    .MemWrite_en_i(MemWrite_en_i), .MemOP_i(MemOP_i),
    .Addr_i(Addr_i), .Wdata_i(Wdata_i), .Rd_i(Rd_i),
    .Stall_o(Stall_o),
    .Dmem_req_o(Dmem_req_o), .Dmem_gnt_i(Dmem_gnt_i),
    .Dmem_we_o(Dmem_we_o), .Dmem_be_o(Dmem_be_o),
    .Dmem_addr_o(Dmem_addr_o), .Dmem_wdata_o(Dmem_wdata_o),
    .Dmem_rvalid_i(Dmem_rvalid_i), .Dmem_rdata_i(Dmem_rdata_i),
    .Ld_valid_o(Ld_valid_o), .Ld_rd_o(Ld_rd_o),
    .Ld_data_o(Ld_data_o),
    .Err_o(Err_o), .Err_code_o(Err_code_o)
  );

  always #5 Clk_i = ~Clk_i;

  task automatic tick;
    @(posedge Clk_i);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd);
    Req_valid_i = 1'b1;
    MemWrite_en_i = we;
    MemOP_i = op;
    Addr_i = a;
    Wdata_i = d;
    Rd_i = rd;
    tick();
    Req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (Req_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b exp 1", Req_ready_o); end
    n_cmp++; if (Stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", Stall_o); end
    n_cmp++; if (Dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b exp 0", Dmem_req_o); end
    n_cmp++; if ({Ld_valid_o, Err_o, Err_code_o} !== 4'b0) begin n_bad++; $display("FAIL rst_pulses got %b exp 0000", {Ld_valid_o, Err_o, Err_code_o}); end
    n_cmp++; if ({Dmem_be_o, Dmem_addr_o, Dmem_wdata_o, Ld_data_o} !== '0) begin n_bad++; $display("FAIL rst_data not zero"); end
    Rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_store_word;
    issue(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd0);
    n_cmp++; if (Dmem_req_o !== 1'b1) begin n_bad++; $display("FAIL sw_req got %b exp 1", Dmem_req_o); end
    n_cmp++; if (Dmem_we_o !== 1'b1) begin n_bad++; $display("FAIL sw_we got %b exp 1", Dmem_we_o); end
    n_cmp++; if (Dmem_be_o !== 4'b1111) begin n_bad++; $display("FAIL sw_be got %b exp 1111", Dmem_be_o); end
    n_cmp++; if (Dmem_addr_o !== 32'h104) begin n_bad++; $display("FAIL sw_addr got %h exp 00000104", Dmem_addr_o); end
    n_cmp++; if (Dmem_wdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata got %h exp deadbeef", Dmem_wdata_o); end
    n_cmp++; if ({Req_ready_o, Stall_o} !== 2'b01) begin n_bad++; $display("FAIL sw_stall got %b exp 01", {Req_ready_o, Stall_o}); end
    Dmem_gnt_i = 1'b1;
    tick();
    Dmem_gnt_i = 1'b0;
    n_cmp++; if (Req_ready_o !== 1'b1) begin n_bad++; $display("FAIL sw_ready_back got %b exp 1", Req_ready_o); end
    n_cmp++; if (Dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL sw_req_drop got %b exp 0", Dmem_req_o); end
  endtask

  task automatic test_store_lanes;
    issue(1'b1, 3'b000, 32'h203, 32'h123456AB, 5'd0);
    n_cmp++; if (Dmem_be_o !== 4'b1000) begin n_bad++; $display("FAIL sb_be got %b exp 1000", Dmem_be_o); end
    n_cmp++; if (Dmem_wdata_o !== 32'hABABABAB) begin n_bad++; $display("FAIL sb_wdata got %h exp abababab", Dmem_wdata_o); end
    n_cmp++; if (Dmem_addr_o !== 32'h200) begin n_bad++; $display("FAIL sb_addr got %h exp 00000200", Dmem_addr_o); end
    Dmem_gnt_i = 1'b1; tick(); Dmem_gnt_i = 1'b0;
    issue(1'b1, 3'b001, 32'h202, 32'hFFFF1234, 5'd0);
    n_cmp++; if (Dmem_be_o !== 4'b1100) begin n_bad++; $display("FAIL sh_be got %b exp 1100", Dmem_be_o); end
    n_cmp++; if (Dmem_wdata_o !== 32'h12341234) begin n_bad++; $display("FAIL sh_wdata got %h exp 12341234", Dmem_wdata_o); end
    Dmem_gnt_i = 1'b1; tick(); Dmem_gnt_i = 1'b0;
  endtask

  task automatic test_load_byte(input logic [2:0] op,
                                input logic [31:0] exp);
    issue(1'b0, op, 32'h101, 32'h0, 5'd7);
    n_cmp++; if ({Dmem_req_o, Dmem_we_o, Dmem_be_o} !== 6'b10_0010) begin n_bad++; $display("FAIL lb_bus got %b exp 100010", {Dmem_req_o, Dmem_we_o, Dmem_be_o}); end
    Dmem_gnt_i = 1'b1; tick(); Dmem_gnt_i = 1'b0;
    n_cmp++; if ({Dmem_req_o, Ld_valid_o} !== 2'b00) begin n_bad++; $display("FAIL lb_wait got %b exp 00", {Dmem_req_o, Ld_valid_o}); end
    Dmem_rvalid_i = 1'b1; Dmem_rdata_i = 32'h0000_80FF;
    tick();
    Dmem_rvalid_i = 1'b0;
    n_cmp++; if (Ld_valid_o !== 1'b1) begin n_bad++; $display("FAIL lb_valid_lat3 got %b exp 1", Ld_valid_o); end
    n_cmp++; if (Ld_data_o !== exp) begin n_bad++; $display("FAIL lb_data op %b got %h exp %h", op, Ld_data_o, exp); end
    n_cmp++; if (Ld_rd_o !== 5'd7) begin n_bad++; $display("FAIL lb_rd got %0d exp 7", Ld_rd_o); end
    n_cmp++; if (Err_o !== 1'b0) begin n_bad++; $display("FAIL lb_noerr got %b exp 0", Err_o); end
    tick();
    n_cmp++; if (Ld_valid_o !== 1'b0) begin n_bad++; $display("FAIL lb_pulse got %b exp 0", Ld_valid_o); end
  endtask

  task automatic test_load_half_delayed;
    issue(1'b0, 3'b001, 32'h102, 32'h0, 5'd3);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({Dmem_req_o, Dmem_be_o, Dmem_addr_o} !== {1'b1, 4'b1100, 32'h100}) begin n_bad++; $display("FAIL lh_hold cyc %0d got %b %b %h", i, Dmem_req_o, Dmem_be_o, Dmem_addr_o); end
      tick();
    end
    Dmem_gnt_i = 1'b1; tick(); Dmem_gnt_i = 1'b0;
    n_cmp++; if (Dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL lh_req_drop got %b exp 0", Dmem_req_o); end
    Dmem_rvalid_i = 1'b1; Dmem_rdata_i = 32'h8001_1234;
    tick();
    Dmem_rvalid_i = 1'b0;
    n_cmp++; if ({Ld_valid_o, Ld_data_o} !== {1'b1, 32'hFFFF8001}) begin n_bad++; $display("FAIL lh_data got %b %h exp 1 ffff8001", Ld_valid_o, Ld_data_o); end
    n_cmp++; if (Ld_rd_o !== 5'd3) begin n_bad++; $display("FAIL lh_rd got %0d exp 3", Ld_rd_o); end
  endtask

  task automatic test_timeout;
    int n;
    issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
    Dmem_gnt_i = 1'b1; tick(); Dmem_gnt_i = 1'b0;
    n = 1;
    while (!Err_o && n < 200) begin
      tick();
      n++;
    end
    n_cmp++; if (n !== 64) begin n_bad++; $display("FAIL tmo_cycles got %0d exp 64", n); end
    n_cmp++; if ({Err_o, Err_code_o} !== 3'b111) begin n_bad++; $display("FAIL tmo_code got %b exp 111", {Err_o, Err_code_o}); end
    n_cmp++; if ({Req_ready_o, Ld_valid_o, Dmem_req_o} !== 3'b100) begin n_bad++; $display("FAIL tmo_idle got %b exp 100", {Req_ready_o, Ld_valid_o, Dmem_req_o}); end
    tick();
    n_cmp++; if (Err_o !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse got %b exp 0", Err_o); end
    Dmem_rvalid_i = 1'b1; Dmem_rdata_i = 32'h5555_5555;
    tick();
    Dmem_rvalid_i = 1'b0;
    n_cmp++; if (Ld_valid_o !== 1'b0) begin n_bad++; $display("FAIL tmo_late_rvalid got %b exp 0", Ld_valid_o); end
  endtask

  task automatic test_illegal;
    issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd1);
    n_cmp++; if ({Err_o, Err_code_o} !== 3'b101) begin n_bad++; $display("FAIL ill_ld got %b exp 101", {Err_o, Err_code_o}); end
    n_cmp++; if ({Dmem_req_o, Req_ready_o} !== 2'b01) begin n_bad++; $display("FAIL ill_nobus got %b exp 01", {Dmem_req_o, Req_ready_o}); end
    tick();
    n_cmp++; if (Err_o !== 1'b0) begin n_bad++; $display("FAIL ill_pulse got %b exp 0", Err_o); end
    issue(1'b1, 3'b100, 32'h100, 32'h0, 5'd0);
    n_cmp++; if ({Err_o, Err_code_o, Dmem_req_o} !== 4'b1010) begin n_bad++; $display("FAIL ill_st got %b exp 1010", {Err_o, Err_code_o, Dmem_req_o}); end
    tick();
  endtask

  task automatic test_misalign;
    issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd4);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if ({Err_o, Err_code_o, Dmem_req_o} !== 4'b1100) begin n_bad++; $display("FAIL mis_trap got %b exp 1100", {Err_o, Err_code_o, Dmem_req_o}); end
    tick();
`else
    n_cmp++; if ({Err_o, Dmem_req_o, Dmem_addr_o} !== {2'b01, 32'h100}) begin n_bad++; $display("FAIL mis_addr got %b %h exp 01 00000100", {Err_o, Dmem_req_o}, Dmem_addr_o); end
    Dmem_gnt_i = 1'b1; tick(); Dmem_gnt_i = 1'b0;
    Dmem_rvalid_i = 1'b1; Dmem_rdata_i = 32'h1122_3344;
    tick();
    Dmem_rvalid_i = 1'b0;
    n_cmp++; if ({Ld_valid_o, Ld_data_o} !== {1'b1, 32'h11223344}) begin n_bad++; $display("FAIL mis_data got %b %h exp 1 11223344", Ld_valid_o, Ld_data_o); end
`endif
  endtask

  task automatic test_reset_wait;
    issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd2);
    Dmem_gnt_i = 1'b1; tick(); Dmem_gnt_i = 1'b0;
    #2 Rst_n_i = 1'b0;
    #1;
    n_cmp++; if ({Req_ready_o, Dmem_req_o} !== 2'b10) begin n_bad++; $display("FAIL rstw_idle got %b exp 10", {Req_ready_o, Dmem_req_o}); end
    #2 Rst_n_i = 1'b1;
    Dmem_rvalid_i = 1'b1; Dmem_rdata_i = 32'hCAFE_0000;
    tick();
    Dmem_rvalid_i = 1'b0;
    n_cmp++; if ({Ld_valid_o, Req_ready_o} !== 2'b01) begin n_bad++; $display("FAIL rstw_rvalid got %b exp 01", {Ld_valid_o, Req_ready_o}); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_lanes();
    test_load_byte(3'b000, 32'hFFFFFF80);
    test_load_byte(3'b100, 32'h00000080);
    test_load_half_delayed();
    test_timeout();
    test_illegal();
    test_misalign();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

endmodule
